// File: rtl/spi_capture_pkg.sv
// spi_capture_pkg
// Shared definitions for the SPI frame-capture stage: default field widths,
// the record-width helper, the packed record layout and the overflow-counter
// width. The optional timestamp field is present when SPI_FRAME_CAPTURE_TIMESTAMP_EN
// is defined.
package spi_capture_pkg;

  localparam int DWIDTH_DEF   = 32;
  localparam int BITCOUNT_DEF = 12;
  localparam int SEQ_DEF      = 16;
  localparam int TS_DEF       = 32;
  localparam int DEPTH_DEF    = 16;
  localparam int OVF_W        = 16;

`ifdef SPI_FRAME_CAPTURE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Record width: seq + nbits + both data words, plus the timestamp if built in.
  function automatic int rec_width(int dw, int bw, int sw, int tw, bit ts_en);
    return sw + bw + 2 * dw + (ts_en ? tw : 0);
  endfunction

  localparam int REC_W = rec_width(DWIDTH_DEF, BITCOUNT_DEF, SEQ_DEF, TS_DEF, TS_EN);

  // Record layout at default widths, MSB first.
  typedef struct packed {
`ifdef SPI_FRAME_CAPTURE_TIMESTAMP_EN
    logic [TS_DEF-1:0]       ts;
`endif
    logic [SEQ_DEF-1:0]      seq;
    logic [BITCOUNT_DEF-1:0] nbits;
    logic [DWIDTH_DEF-1:0]   master;
    logic [DWIDTH_DEF-1:0]   slave;
  } rec_t;

endpackage

// File: rtl/spi_frame_capture_if.sv
// spi_frame_capture_if
// Avalon-ST source bus carrying capture records.
//   source_valid : record available (driven by the source)
//   source_ready : sink accepts the record this cycle
//   source_data  : packed record, RECW bits
// Modports: master = source side, slave = sink side.
interface spi_frame_capture_if #(
  parameter int RECW = spi_capture_pkg::REC_W
);
  logic            source_valid;
  logic            source_ready;
  logic [RECW-1:0] source_data;

  modport master (output source_valid, output source_data, input source_ready);
  modport slave  (input source_valid, input source_data, output source_ready);
endinterface

// File: rtl/spi_capture_sfifo.sv
// spi_capture_sfifo
// Synchronous first-word-fall-through FIFO, WIDTH bits by DEPTH entries
// (DEPTH a power of 2, at least 2). Synchronous active-high reset.
//   push/wdata : write; caller asserts push only when not full or when popping
//   pop        : remove head; ignored when empty
//   rdata      : head record, zero when empty
//   full/empty : status from pointers
//   level      : records held
module spi_capture_sfifo #(
  parameter int WIDTH = 92,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_pop;

  assign do_pop = pop & ~empty;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level  = wr_ptr - rd_ptr;
  assign rdata  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: storage is deliberately not reset; the pointers alone say which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/spi_frame_capture.sv
// spi_frame_capture
// Detects the end of each SPI transaction seen by the snooper, tags the
// master word, slave word and bit count with a sequence number (and, when
// SPI_FRAME_CAPTURE_TIMESTAMP_EN is defined, a free-running timestamp),
// buffers the records and streams them out on an Avalon-ST source.
// Ports:
//   clk, reset     : single clock, synchronous active-high reset
//   capture_en     : frame ends ignored while low
//   frame_idle     : snooper data_valid, high while SS is deasserted
//   master_data    : shifted MOSI word
//   slave_data     : shifted MISO word
//   nbits_received : index of last bit received (count - 1)
//   src            : Avalon-ST source (valid/ready/data)
//   fifo_level     : records currently buffered
//   overflow_count : dropped records, saturating
module spi_frame_capture
  import spi_capture_pkg::*;
#(
  parameter int DWIDTH        = DWIDTH_DEF,
  parameter int BITCOUNTWIDTH = BITCOUNT_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter int SEQWIDTH      = SEQ_DEF,
  parameter int TSWIDTH       = TS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     capture_en,
  input  logic                     frame_idle,
  input  logic [DWIDTH-1:0]        master_data,
  input  logic [DWIDTH-1:0]        slave_data,
  input  logic [BITCOUNTWIDTH-1:0] nbits_received,
  spi_frame_capture_if.master      src,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [OVF_W-1:0]         overflow_count
);
  localparam int RECW = rec_width(DWIDTH, BITCOUNTWIDTH, SEQWIDTH, TSWIDTH, TS_EN);

  logic                     idle_q;
  logic                     armed;
  logic                     end_evt;
  logic [SEQWIDTH-1:0]      seq;
  logic [BITCOUNTWIDTH-1:0] nbits;
  logic [RECW-1:0]          rec;
  logic                     fifo_full, fifo_empty;
  logic                     pop_fire, push_ok;

  // idle_q resets high and armed low, so neither power-up nor a frame_idle
  // level present at reset release looks like a rising edge.
  assign end_evt  = frame_idle & ~idle_q & armed & capture_en;
  assign nbits    = nbits_received + 1'b1;
  assign pop_fire = ~fifo_empty & src.source_ready;
  // A full FIFO still takes the record if its head leaves in the same cycle.
  assign push_ok  = ~fifo_full | pop_fire;

  assign src.source_valid = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q         <= 1'b1;
      armed          <= 1'b0;
      seq            <= '0;
      overflow_count <= '0;
    end else begin
      idle_q <= frame_idle;
      if (!frame_idle)  armed <= 1'b1;
      else if (end_evt) armed <= 1'b0;
      // Sequence advances on every counted frame, kept or dropped, so host
      // software sees gaps where records were lost.
      if (end_evt) seq <= seq + 1'b1;
      if (end_evt && !push_ok && overflow_count != '1)
        overflow_count <= overflow_count + 1'b1;
    end
  end

`ifdef SPI_FRAME_CAPTURE_TIMESTAMP_EN
  logic [TSWIDTH-1:0] ts;

  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + 1'b1;
  end

  assign rec = {ts, seq, nbits, master_data, slave_data};
`else
  assign rec = {seq, nbits, master_data, slave_data};
`endif

  spi_capture_sfifo #(
    .WIDTH (RECW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (end_evt & push_ok),
    .pop   (pop_fire),
    .wdata (rec),
    .rdata (src.source_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );
endmodule

// File: tb/tb_spi_frame_capture.sv
// tb_spi_frame_capture
// Directed bench for spi_frame_capture. A queue model of the record buffer
// predicts valid, level, head record and overflow count every cycle; directed
// scenarios add hand-computed literal expectations.
module tb_spi_frame_capture;
  import spi_capture_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        capture_en;
  logic        frame_idle;
  logic [31:0] master_data, slave_data;
  logic [11:0] nbits_received;
  logic [4:0]  fifo_level;
  logic [15:0] overflow_count;

  always #5 clk = ~clk;

  spi_frame_capture_if #(.RECW(REC_W)) bus ();

  spi_frame_capture dut (
    .clk            (clk),
    .reset          (reset),
    .capture_en     (capture_en),
    .frame_idle     (frame_idle),
    .master_data    (master_data),
    .slave_data     (slave_data),
    .nbits_received (nbits_received),
    .src            (bus.master),
    .fifo_level     (fifo_level),
    .overflow_count (overflow_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  rec_t        q[$];
  rec_t        beats[$];
  int          beat_cyc[$];
  rec_t        r;
  logic [15:0] seq_m;
  logic [15:0] ovf_m;
  logic [31:0] ts_m;
  bit          chk_en = 0;
  bit          frame_end = 0;
  bit          rand_rdy = 0;
  bit          prev_stall = 0;
  logic [REC_W-1:0] prev_data;
  int          cyc = 0;
  int          ev_cyc;

  always @(posedge clk) cyc++;

  // Outputs are compared mid-cycle; the model then advances to what the
  // next edge must produce from the current inputs.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", bus.source_valid, q.size() != 0);
      check("level", fifo_level, q.size());
      check("overflow", overflow_count, ovf_m);
      if (q.size() != 0) check("data", bus.source_data, q[0]);
      if (prev_stall) check("stall_hold", bus.source_data, prev_data);
      if (bus.source_valid && bus.source_ready) begin
        beats.push_back(rec_t'(bus.source_data));
        beat_cyc.push_back(cyc);
      end
      prev_stall = bus.source_valid && !bus.source_ready && !reset;
      prev_data  = bus.source_data;
    end
    if (reset) begin
      q.delete();
      seq_m  = '0;
      ovf_m  = '0;
      ts_m   = '0;
      chk_en = 1;
      prev_stall = 0;
    end else begin
      if (q.size() != 0 && bus.source_ready) void'(q.pop_front());
      if (frame_end && capture_en) begin
`ifdef SPI_FRAME_CAPTURE_TIMESTAMP_EN
        r.ts = ts_m;
`endif
        r.seq    = seq_m;
        r.nbits  = nbits_received + 12'd1;
        r.master = master_data;
        r.slave  = slave_data;
        seq_m++;
        if (q.size() < DEPTH_DEF) q.push_back(r);
        else if (ovf_m != 16'hFFFF) ovf_m++;
      end
      ts_m++;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) bus.source_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [31:0] m, input logic [31:0] s,
                       input logic [11:0] nb, input int low);
    frame_idle     = 1'b0;
    master_data    = m;
    slave_data     = s;
    nbits_received = nb;
    repeat (low) step();
    frame_idle = 1'b1;
    frame_end  = 1'b1;
    ev_cyc     = cyc;
    step();
    frame_end = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    frame_idle = 1'b1;
    frame_end  = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (fifo_level == 0 && !bus.source_valid) break;
      step();
    end
    check("drain_done", fifo_level, 5'd0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    reset            = 1'b1;
    capture_en       = 1'b1;
    frame_idle       = 1'b1;
    master_data      = '0;
    slave_data       = '0;
    nbits_received   = '0;
    bus.source_ready = 1'b1;
    repeat (3) step();

    // Reset values.
    check("rst_valid", bus.source_valid, 1'b0);
    check("rst_data", bus.source_data, '0);
    check("rst_level", fifo_level, 5'd0);
    check("rst_overflow", overflow_count, 16'd0);

    // frame_idle held high through reset release: nothing appears.
    reset = 1'b0;
    repeat (100) step();
    check("glitch_beats", beats.size(), 0);

    // Single frame.
    beats.delete();
    beat_cyc.delete();
    frame(32'hA5A5_0001, 32'h5A5A_0002, 12'd31, 2);
    repeat (3) step();
    check("single_count", beats.size(), 1);
    if (beats.size() == 1) begin
      check("single_seq", beats[0].seq, 16'd0);
      check("single_nbits", beats[0].nbits, 12'd32);
      check("single_master", beats[0].master, 32'hA5A5_0001);
      check("single_slave", beats[0].slave, 32'h5A5A_0002);
      check("single_latency", beat_cyc[0] - ev_cyc, 1);
    end
    check("single_level", fifo_level, 5'd0);

    // Bit-count wrap: last index 4095 gives a count of 0 at 12 bits.
    frame(32'h0000_1111, 32'h0000_2222, 12'hFFF, 1);
    repeat (3) step();
    check("wrap_count", beats.size(), 2);
    if (beats.size() == 2) begin
      check("wrap_nbits", beats[1].nbits, 12'd0);
      check("wrap_seq", beats[1].seq, 16'd1);
    end

    // Gating: three ignored frames, then one captured frame with seq 0.
    do_reset();
    beats.delete();
    capture_en = 1'b0;
    for (int i = 0; i < 3; i++) frame(32'hDEAD_0000 + i, 32'hBEEF_0000 + i, 12'd7, 2);
    capture_en = 1'b1;
    frame(32'hC0DE_0004, 32'hF00D_0004, 12'd15, 2);
    repeat (3) step();
    check("gate_count", beats.size(), 1);
    if (beats.size() == 1) begin
      check("gate_seq", beats[0].seq, 16'd0);
      check("gate_master", beats[0].master, 32'hC0DE_0004);
    end

    // Overflow: 20 frames into a stalled 16-deep buffer.
    do_reset();
    beats.delete();
    bus.source_ready = 1'b0;
    for (int i = 0; i < 20; i++) frame(32'h1000_0000 + i, 32'h2000_0000 + i, 12'd7, 1);
    step();
    check("ovf_level", fifo_level, 5'd16);
    check("ovf_count", overflow_count, 16'd4);

    // Full buffer, frame ends in the same cycle as a pop.
    frame_idle  = 1'b0;
    master_data = 32'h3000_0014;
    step();
    frame_idle       = 1'b1;
    frame_end        = 1'b1;
    bus.source_ready = 1'b1;
    step();
    frame_end = 1'b0;
    check("fullpop_level", fifo_level, 5'd16);
    check("fullpop_ovf", overflow_count, 16'd4);
    drain();
    check("ovf_drain_count", beats.size(), 17);
    if (beats.size() == 17) begin
      for (int i = 0; i < 16; i++) check("ovf_drain_seq", beats[i].seq, 16'(i));
      check("ovf_next_seq", beats[16].seq, 16'd20);
      check("ovf_next_master", beats[16].master, 32'h3000_0014);
    end
    check("ovf_final", overflow_count, 16'd4);

    // Random backpressure across 50 frames.
    do_reset();
    beats.delete();
    rand_rdy = 1;
    for (int i = 0; i < 50; i++)
      frame($urandom, $urandom, 12'($urandom_range(0, 4095)), $urandom_range(2, 4));
    rand_rdy = 0;
    step();
    bus.source_ready = 1'b1;
    drain();
    check("bp_count", beats.size(), 50);
    check("bp_overflow", overflow_count, 16'd0);
    for (int i = 0; i < beats.size(); i++) check("bp_seq", beats[i].seq, 16'(i));
`ifdef SPI_FRAME_CAPTURE_TIMESTAMP_EN
    for (int i = 1; i < beats.size(); i++)
      check("ts_step", (beats[i].ts - beats[i-1].ts) >= 32'd2, 1'b1);
`endif

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
